// File: rtl/conditional_merge.sv
// Conditional merge: gathers a timestep token plus one or two packets into a
// bundle, then emits the bundle as one or two output beats with r_last marking the end.
module conditional_merge #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ts_valid,
  input  logic             ts_data,
  output logic             ts_ready,
  input  logic             l0_valid,
  input  logic [WIDTH-1:0] l0_data,
  output logic             l0_ready,
  input  logic             l1_valid,
  input  logic [WIDTH-1:0] l1_data,
  output logic             l1_ready,
  output logic             r_valid,
  output logic [WIDTH-1:0] r_data,
  output logic             r_last,
  input  logic             r_ready,
  output logic [CNT_W-1:0] bundle_cnt
);

  typedef enum logic [1:0] {COLLECT, SEND0, SEND1} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic             r_started;
  logic             r_ts_full;
  logic             r_ts_q;
  logic             r_p0_full;
  logic             r_p1_full;
  logic [WIDTH-1:0] r_p0_q;
  logic [WIDTH-1:0] r_p1_q;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_last;
  logic [CNT_W-1:0] r_cnt;

  logic w_collect;
  logic w_complete;
  logic w_ts_hs;
  logic w_l0_hs;
  logic w_l1_hs;
  logic w_load0;
  logic w_load1;
  logic w_done;

  assign w_collect  = (r_state == COLLECT);
  assign w_complete = r_ts_full && r_p0_full && (r_ts_q || r_p1_full);

  // r_started keeps every ready low until the first edge after reset release.
  assign ts_ready = r_started && w_collect && !r_ts_full;
  assign l0_ready = r_started && w_collect && !r_p0_full;
  assign l1_ready = r_started && w_collect && !r_p1_full && r_ts_full && !r_ts_q;

  assign w_ts_hs = ts_valid && ts_ready;
  assign w_l0_hs = l0_valid && l0_ready;
  assign w_l1_hs = l1_valid && l1_ready;

  assign r_valid    = !w_collect;
  assign r_data     = r_out_data;
  assign r_last     = r_out_last;
  assign bundle_cnt = r_cnt;

  always_comb begin
    w_state_next = r_state;
    w_load0      = 1'b0;
    w_load1      = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      COLLECT: begin
        if (w_complete) begin
          w_state_next = SEND0;
          w_load0      = 1'b1;
        end
      end
      SEND0: begin
        if (r_ready) begin
          if (r_ts_q) begin
            w_state_next = COLLECT;
            w_done       = 1'b1;
          end else begin
            w_state_next = SEND1;
            w_load1      = 1'b1;
          end
        end
      end
      SEND1: begin
        if (r_ready) begin
          w_state_next = COLLECT;
          w_done       = 1'b1;
        end
      end
      default: w_state_next = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= COLLECT;
      r_started <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_started <= 1'b1;
    end
  end

  // Holding registers; flags clear only when the bundle's final beat leaves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ts_full <= 1'b0;
      r_ts_q    <= 1'b0;
      r_p0_full <= 1'b0;
      r_p1_full <= 1'b0;
      r_p0_q    <= '0;
      r_p1_q    <= '0;
    end else if (w_done) begin
      r_ts_full <= 1'b0;
      r_p0_full <= 1'b0;
      r_p1_full <= 1'b0;
    end else begin
      if (w_ts_hs) begin
        r_ts_full <= 1'b1;
        r_ts_q    <= ts_data;
      end
      if (w_l0_hs) begin
        r_p0_full <= 1'b1;
        r_p0_q    <= l0_data;
      end
      if (w_l1_hs) begin
        r_p1_full <= 1'b1;
        r_p1_q    <= l1_data;
      end
    end
  end

  // Output beat registers load on state entry, so they hold through stalls and COLLECT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data <= '0;
      r_out_last <= 1'b0;
      r_cnt      <= '0;
    end else begin
      if (w_load0) begin
        r_out_data <= r_p0_q;
        r_out_last <= r_ts_q;
      end else if (w_load1) begin
        r_out_data <= r_p1_q;
        r_out_last <= 1'b1;
      end
      if (w_done) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_conditional_merge.sv
// Scoreboard bench for conditional_merge: drivers push expected beats, an
// independent monitor pops and compares them on every output handshake.
`timescale 1ns/1ps
module tb_conditional_merge;
  localparam int W  = 4;
  localparam int CW = 2;
  localparam int P  = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ts_valid, ts_data, ts_ready;
  logic          l0_valid, l1_valid, l0_ready, l1_ready;
  logic [W-1:0]  l0_data, l1_data, r_data;
  logic          r_valid, r_last, r_ready;
  logic [CW-1:0] bundle_cnt;

  always #(P/2) clk = ~clk;

  conditional_merge #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .ts_valid(ts_valid), .ts_data(ts_data), .ts_ready(ts_ready),
    .l0_valid(l0_valid), .l0_data(l0_data), .l0_ready(l0_ready),
    .l1_valid(l1_valid), .l1_data(l1_data), .l1_ready(l1_ready),
    .r_valid(r_valid), .r_data(r_data), .r_last(r_last), .r_ready(r_ready),
    .bundle_cnt(bundle_cnt)
  );

  logic [W:0]    exp_q[$];
  int            n_cmp = 0;
  int            n_err = 0;
  logic [CW-1:0] exp_cnt = '0;
  bit            ts0_ok = 1'b0;
  bit            rr_rand = 1'b0;
  time           last_cap_t = 0;
  bit            prev_v = 1'b0;
  bit            stall = 1'b0;
  bit            hs = 1'b0;
  logic [W:0]    held;
  logic [W:0]    e;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive_ch(input int ch, input logic [W-1:0] d, input int dly);
    bit done;
    done = 1'b0;
    repeat (dly) @(negedge clk);
    case (ch)
      0:       begin ts_valid = 1'b1; ts_data = d[0]; end
      1:       begin l0_valid = 1'b1; l0_data = d; end
      default: begin l1_valid = 1'b1; l1_data = d; end
    endcase
    for (int t = 0; t < 500 && !done; t++) begin
      case (ch)
        0:       done = ts_ready;
        1:       done = l0_ready;
        default: done = l1_ready;
      endcase
      @(posedge clk);
      if (done) begin
        if (ch == 0) ts0_ok = (d[0] == 1'b0);
        if ($time > last_cap_t) last_cap_t = $time;
      end
      @(negedge clk);
    end
    case (ch)
      0:       ts_valid = 1'b0;
      1:       l0_valid = 1'b0;
      default: l1_valid = 1'b0;
    endcase
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout ch%0d: got not-accepted expected accepted", ch);
    end
  endtask

  task automatic run_bundle(input logic t, input logic [W-1:0] a, input logic [W-1:0] b,
                            input int dt, input int d0, input int d1);
    if (t) begin
      exp_q.push_back({1'b1, a});
    end else begin
      exp_q.push_back({1'b0, a});
      exp_q.push_back({1'b1, b});
    end
    fork
      drive_ch(0, W'(t), dt);
      drive_ch(1, a, d0);
      begin
        if (!t) drive_ch(2, b, d1);
      end
    join
  endtask

  task automatic drain();
    for (int t = 0; t < 2000 && exp_q.size() != 0; t++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("drain_empty", exp_q.size(), 0);
  endtask

  task automatic wait_valid();
    for (int t = 0; t < 200 && !r_valid; t++) @(negedge clk);
    chk("wait_valid", r_valid, 1);
  endtask

  // Monitor: samples 1ns after each falling edge, all inputs settled by then.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      hs = 1'b0;
      if (!rst_n) begin
        prev_v = 1'b0;
        stall  = 1'b0;
      end else begin
        chk("bundle_cnt", bundle_cnt, exp_cnt);
        chk("l1_ready_gate", l1_ready && !ts0_ok, 0);
        if (r_valid) chk("in_ready_during_send", {ts_ready, l0_ready, l1_ready}, 0);
        if (stall) begin
          chk("valid_hold", r_valid, 1);
          chk("beat_hold", {r_last, r_data}, held);
        end
        if (r_valid && !prev_v) chk("valid_rise_edge", 32'($time - 6), 32'(last_cap_t + P));
        prev_v = r_valid;
        stall  = r_valid && !r_ready;
        held   = {r_last, r_data};
        hs     = r_valid && r_ready;
        if (hs) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_beat: got %0h expected none", {r_last, r_data});
          end else begin
            e = exp_q.pop_front();
            chk("beat", {r_last, r_data}, e);
          end
        end
      end
      @(posedge clk);
      if (hs && held[W]) begin
        exp_cnt = exp_cnt + 1'b1;
        ts0_ok  = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rr_rand) r_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    logic          t;
    logic [W-1:0]  a, b;
    ts_valid = 1'b0; ts_data = 1'b0;
    l0_valid = 1'b0; l0_data = '0;
    l1_valid = 1'b0; l1_data = '0;
    r_ready  = 1'b0;
    #1;
    chk("rst_r_valid", r_valid, 0);
    chk("rst_r_data", r_data, 0);
    chk("rst_r_last", r_last, 0);
    chk("rst_cnt", bundle_cnt, 0);
    chk("rst_readies", {ts_ready, l0_ready, l1_ready}, 0);
    repeat (2) @(negedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_readies", {ts_ready, l0_ready, l1_ready}, 3'b110);

    // Single-packet bundle, ts and l0 together.
    r_ready = 1'b1;
    run_bundle(1'b1, 4'hA, 4'h0, 0, 0, 0);
    drain();
    chk("cnt_after_single", bundle_cnt, 1);

    // Two-packet bundle with l1 offered before ts.
    run_bundle(1'b0, 4'h3, 4'h5, 3, 1, 0);
    drain();

    // Backpressure in SEND0 and SEND1.
    r_ready = 1'b0;
    run_bundle(1'b0, 4'h6, 4'h9, 0, 2, 1);
    wait_valid();
    repeat (4) @(negedge clk);
    r_ready = 1'b1;
    @(negedge clk);
    r_ready = 1'b0;
    repeat (4) @(negedge clk);
    r_ready = 1'b1;
    drain();

    // Reset while in SEND1 discards the pending second beat.
    r_ready = 1'b0;
    run_bundle(1'b0, 4'h1, 4'h2, 0, 0, 0);
    wait_valid();
    r_ready = 1'b1;
    @(negedge clk);
    r_ready = 1'b0;
    @(negedge clk);
    chk("send1_beat", {r_last, r_data}, {1'b1, 4'h2});
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_r_valid", r_valid, 0);
    chk("midrst_cnt", bundle_cnt, 0);
    chk("midrst_r_data", {r_last, r_data}, 0);
    chk("midrst_readies", {ts_ready, l0_ready, l1_ready}, 0);
    exp_q.delete();
    exp_cnt = '0;
    ts0_ok  = 1'b0;
    @(negedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    chk("post_midrst_readies", {ts_ready, l0_ready, l1_ready}, 3'b110);

    // Five back-to-back single-packet bundles: counter 1,2,3,0,1.
    r_ready = 1'b1;
    for (int i = 0; i < 5; i++) run_bundle(1'b1, W'(i + 1), 4'h0, 0, 0, 0);
    drain();
    chk("cnt_wrap", bundle_cnt, 1);

    // Mixed random bundles with random readiness downstream.
    rr_rand = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      t = 1'($urandom_range(0, 1));
      a = W'($urandom);
      b = W'($urandom);
      run_bundle(t, a, b, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
    end
    drain();
    rr_rand = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
